// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: grants up to NUM_CDB of NUM_REQ functional-unit
// results per cycle (starved first, then high-priority, then round-robin)
// and broadcasts the granted tags one cycle later.
module cdb_arbiter #(
   parameter int unsigned          NUM_REQ       = 8,
   parameter int unsigned          NUM_CDB       = 2,
   parameter int unsigned          TAG_W         = 6,
   parameter int unsigned          STARVE_LIMIT  = 4,
   parameter logic [NUM_REQ-1:0]   HIGH_PRI_MASK = 8'b1100_0000,
   localparam int unsigned         SRC_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       flush,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
   output logic [NUM_REQ-1:0]         grant,
   output logic [NUM_CDB-1:0]         cdb_valid,
   output logic [NUM_CDB*TAG_W-1:0]   cdb_tag,
   output logic [NUM_CDB*SRC_W-1:0]   cdb_src,
   output logic [SRC_W-1:0]           rr_ptr_dbg
);

   logic [3:0]         starve_cnt [NUM_REQ];
   logic [SRC_W-1:0]   rr_ptr;
   logic [NUM_REQ-1:0] cls_starved;
   logic [NUM_REQ-1:0] cls_high;
   logic [NUM_REQ-1:0] cls_rr;

   logic [NUM_CDB-1:0] sel_vld;
   logic [SRC_W-1:0]   sel_src [NUM_CDB];
   logic [TAG_W-1:0]   sel_tag [NUM_CDB];
   logic               rr_hit;
   logic [SRC_W-1:0]   rr_next;

   assign rr_ptr_dbg = rr_ptr;

   // Split the active requests into the three priority classes.
   always_comb begin
      cls_starved = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cls_starved[i] = req[i] && (starve_cnt[i] == 4'(STARVE_LIMIT));
      end
      cls_high = req & HIGH_PRI_MASK & ~cls_starved;
      cls_rr   = req & ~HIGH_PRI_MASK & ~cls_starved;
   end

   // Walk the three classes as one ordered list of 3*NUM_REQ slots and hand
   // out ports in order; only the last class rotates from rr_ptr.
   always_comb begin
      int unsigned n;
      int unsigned idx;
      int unsigned cls;
      int unsigned off;
      logic        cand;
      n       = 0;
      idx     = 0;
      cls     = 0;
      off     = 0;
      cand    = 1'b0;
      grant   = '0;
      sel_vld = '0;
      rr_hit  = 1'b0;
      rr_next = rr_ptr;
      for (int unsigned k = 0; k < NUM_CDB; k++) begin
         sel_src[k] = '0;
         sel_tag[k] = '0;
      end
      if (!reset && !flush) begin
         for (int unsigned p = 0; p < 3 * NUM_REQ; p++) begin
            cls = p / NUM_REQ;
            off = p % NUM_REQ;
            idx = (cls < 2) ? off : ((32'(rr_ptr) + off) % NUM_REQ);
            cand = (cls == 0) ? cls_starved[idx] :
                   (cls == 1) ? cls_high[idx]    : cls_rr[idx];
            if (cand && (n < NUM_CDB)) begin
               grant[idx]   = 1'b1;
               sel_vld[n]   = 1'b1;
               sel_src[n]   = SRC_W'(idx);
               sel_tag[n]   = req_tag[idx*TAG_W +: TAG_W];
               n            = n + 1;
               if (cls == 2) begin
                  rr_hit  = 1'b1;
                  rr_next = (idx == NUM_REQ - 1) ? '0 : SRC_W'(idx + 1);
               end
            end
         end
      end
   end

   // Broadcast registers, round-robin pointer and starvation counters.
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         cdb_valid <= '0;
         cdb_tag   <= '0;
         cdb_src   <= '0;
         rr_ptr    <= '0;
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            starve_cnt[i] <= '0;
         end
      end else begin
         cdb_valid <= sel_vld;
         for (int unsigned k = 0; k < NUM_CDB; k++) begin
            cdb_tag[k*TAG_W +: TAG_W] <= sel_tag[k];
            cdb_src[k*SRC_W +: SRC_W] <= sel_src[k];
         end
         if (rr_hit) begin
            rr_ptr <= rr_next;
         end
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req[i] && !grant[i]) begin
               if (starve_cnt[i] != 4'(STARVE_LIMIT)) begin
                  starve_cnt[i] <= starve_cnt[i] + 4'd1;
               end
            end else begin
               starve_cnt[i] <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and held-until-grant random checks for cdb_arbiter.
// u_def uses the default high-priority mask, u_rr uses a zero mask.
module tb_cdb_arbiter;

   localparam int NR = 8;
   localparam int NC = 2;
   localparam int TW = 6;
   localparam int SW = 3;
   localparam int SL = 4;

   logic             clock = 1'b0;
   logic             reset;
   logic             flush;
   logic [NR-1:0]    req;
   logic [NR*TW-1:0] req_tag;

   logic [NR-1:0]    grant_d,  grant_r;
   logic [NC-1:0]    valid_d,  valid_r;
   logic [NC*TW-1:0] tag_d,    tag_r;
   logic [NC*SW-1:0] src_d,    src_r;
   logic [SW-1:0]    rr_d,     rr_r;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   cdb_arbiter u_def (
      .clock(clock), .reset(reset), .flush(flush), .req(req), .req_tag(req_tag),
      .grant(grant_d), .cdb_valid(valid_d), .cdb_tag(tag_d), .cdb_src(src_d),
      .rr_ptr_dbg(rr_d)
   );

   cdb_arbiter #(.HIGH_PRI_MASK(8'h00)) u_rr (
      .clock(clock), .reset(reset), .flush(flush), .req(req), .req_tag(req_tag),
      .grant(grant_r), .cdb_valid(valid_r), .cdb_tag(tag_r), .cdb_src(src_r),
      .rr_ptr_dbg(rr_r)
   );

   // Count one comparison and report it when observed differs from expected.
   task automatic check_val(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, obs, exp);
      end
   endtask

   // Stimulus and checks; inputs change on the falling edge.
   initial begin
      logic [NR-1:0]    prev_g;
      logic [NR*TW-1:0] prev_tag;
      logic [NR-1:0]    seen;
      logic             bad;
      logic [SW-1:0]    s;
      logic [TW-1:0]    t;
      int               wait_c [NR];

      reset = 1'b1; flush = 1'b0; req = '1; req_tag = '0;

      // Reset held with all requests: no grants, cleared outputs.
      @(negedge clock);
      check_val("rst_grant",  grant_r, 0);
      check_val("rst_valid",  valid_r, 0);
      check_val("rst_tag",    tag_r,   0);
      check_val("rst_src",    src_r,   0);
      check_val("rst_rr",     rr_r,    0);

      // All requesting, zero mask: ports 0,1 go to requesters 0,1.
      reset = 1'b0; req = 8'hFF;
      #1;
      check_val("ff_grant_rr",  grant_r, 8'h03);
      check_val("ff_grant_def", grant_d, 8'hC0);
      @(negedge clock);
      check_val("ff_valid", valid_r, 2'b11);
      check_val("ff_src",   src_r,   {3'd1, 3'd0});
      check_val("ff_rr",    rr_r,    3'd2);
      check_val("ff_rr_def", rr_d,   3'd0);

      // Walk rr_ptr to 6, then wrap across 7 -> 0.
      req = 8'h0C; #1; check_val("g_0c", grant_r, 8'h0C);
      @(negedge clock); check_val("rr_4", rr_r, 3'd4);
      req = 8'h30;
      @(negedge clock); check_val("rr_6", rr_r, 3'd6);
      req = 8'hC1; #1; check_val("wrap_grant", grant_r, 8'hC0);
      @(negedge clock);
      check_val("wrap_rr",  rr_r,  3'd0);
      check_val("wrap_src", src_r, {3'd7, 3'd6});
      req = 8'h01; #1; check_val("held0_grant", grant_r, 8'h01);
      @(negedge clock); check_val("held0_rr", rr_r, 3'd1);

      // Idle cycle: nothing granted, pointer holds.
      req = 8'h00; #1; check_val("idle_grant", grant_r, 0);
      @(negedge clock);
      check_val("idle_valid", valid_r, 0);
      check_val("idle_rr",    rr_r,    3'd1);

      // Single request with tag 37 lands on port 0.
      req = 8'h01; req_tag[0 +: TW] = 6'd37;
      @(negedge clock);
      check_val("one_valid", valid_r, 2'b01);
      check_val("one_tag",   tag_r,   {6'd0, 6'd37});
      check_val("one_src",   src_r,   0);

      // Move pointer to 5, then flush against full request.
      req = 8'h06;
      @(negedge clock); check_val("rr_3", rr_r, 3'd3);
      req = 8'h18;
      @(negedge clock); check_val("rr_5", rr_r, 3'd5);
      flush = 1'b1; req = 8'hFF; #1;
      check_val("flush_grant_rr",  grant_r, 0);
      check_val("flush_grant_def", grant_d, 0);
      @(negedge clock);
      check_val("flush_valid", valid_r, 0);
      check_val("flush_rr",    rr_r,    0);
      flush = 1'b0;

      // Grant then reset: the reset cycle's requests are never broadcast.
      @(negedge clock);
      check_val("pre_rst_valid", valid_r, 2'b11);
      reset = 1'b1; #1;
      check_val("mid_rst_grant", grant_r, 0);
      @(negedge clock);
      check_val("mid_rst_valid", valid_r, 0);
      check_val("mid_rst_rr",    rr_r,    0);
      check_val("mid_rst_src",   src_r,   0);

      // Default mask with 6,7,0 held: bit 0 wins after four denials, twice.
      reset = 1'b0; req = 8'hC1;
      for (int c = 1; c <= 10; c++) begin
         #1;
         check_val($sformatf("starve_c%0d", c), grant_d, (c == 5 || c == 10) ? 8'h41 : 8'hC0);
         @(negedge clock);
         if (c == 5) begin
            check_val("starve_src",   src_d, {3'd6, 3'd0});
            check_val("starve_rr",    rr_d,  3'd0);
         end
      end

      // Random held-until-grant traffic on the zero-mask instance.
      reset = 1'b1; req = '0; req_tag = '0;
      @(negedge clock);
      reset = 1'b0;
      prev_g = '0; prev_tag = '0;
      for (int i = 0; i < NR; i++) wait_c[i] = 0;
      for (int c = 0; c < 10000; c++) begin
         seen = '0; bad = 1'b0;
         for (int k = 0; k < NC; k++) begin
            s = src_r[k*SW +: SW];
            t = tag_r[k*TW +: TW];
            if (valid_r[k]) begin
               if (seen[s] || !prev_g[s] || (t != prev_tag[s*TW +: TW])) bad = 1'b1;
               seen[s] = 1'b1;
            end else if (s != 0 || t != 0) begin
               bad = 1'b1;
            end
         end
         check_val("rand_bcast", seen, prev_g);
         check_val("rand_port",  bad,  0);
         for (int i = 0; i < NR; i++) begin
            if (!(req[i] && !prev_g[i])) begin
               req[i] = ($urandom_range(0, 2) != 0);
               req_tag[i*TW +: TW] = TW'($urandom);
            end
         end
         #1;
         check_val("rand_pop", ($countones(grant_r) > NC), 0);
         for (int i = 0; i < NR; i++) begin
            if (req[i]) begin
               if (grant_r[i]) begin
                  check_val("rand_wait", (wait_c[i] + 1 > SL + 1), 0);
                  wait_c[i] = 0;
               end else begin
                  wait_c[i]++;
               end
            end else begin
               wait_c[i] = 0;
            end
         end
         prev_g   = grant_r;
         prev_tag = req_tag;
         @(negedge clock);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
